// File: rtl/ds_serial_engine.sv
// ds_serial_engine
// Drives the DS1302 3-wire bus for one register transaction at a time.
// A write sends the command byte and then the data byte. A read sends the
// command byte and then captures eight bits from the device. Both are sent
// LSB first.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   func_start    2'b10 write, 2'b01 read, 2'b00 idle, 2'b11 ignored
//   register_addr DS1302 command byte (bit0 = RD/W)
//   write_data    data byte for writes
//   func_done     one-cycle pulse at the end of a transaction
//   read_data     byte captured by the last completed read
//   ds_rst        DS1302 CE, active high
//   ds_sclk       DS1302 SCLK
//   ds_sio        DS1302 bidirectional I/O
module ds_serial_engine #(
    parameter int HALF_PERIOD = 50,
    parameter int CE_SETUP    = 200,
    parameter int CE_HOLD     = 50,
    parameter int CE_RECOVER  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] func_start,
    input  logic [7:0] register_addr,
    input  logic [7:0] write_data,
    output logic       func_done,
    output logic [7:0] read_data,
    output logic       ds_rst,
    output logic       ds_sclk,
    inout  wire        ds_sio
);

    localparam int MAX_A = (HALF_PERIOD > CE_SETUP) ? HALF_PERIOD : CE_SETUP;
    localparam int MAX_B = (CE_HOLD > CE_RECOVER) ? CE_HOLD : CE_RECOVER;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CE_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CE_HOLD - 1);
    localparam logic [CW-1:0] REC_LAST   = CW'(CE_RECOVER - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_REARM   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    slot_q, slot_d, next_slot;
    logic          phase_q, phase_d;   // 1 while SCLK is in its high half
    logic          mode_rd_q, mode_rd_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rst_q, rst_d;
    logic          sclk_q, sclk_d;
    logic          done_q, done_d;
    logic          oe_q, oe_d;
    logic          sio_q, sio_d;

    assign cnt_inc   = cnt_q + CW'(1);
    assign next_slot = slot_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        slot_d    = slot_q;
        phase_d   = phase_q;
        mode_rd_d = mode_rd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        rst_d     = rst_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
        oe_d      = oe_q;
        sio_d     = sio_q;

        case (state_q)
            ST_IDLE: begin
                if (func_start == 2'b10 || func_start == 2'b01) begin
                    state_d   = ST_SETUP;
                    mode_rd_d = func_start[0];
                    addr_d    = register_addr;
                    data_d    = write_data;
                    rst_d     = 1'b1;
                    oe_d      = 1'b1;
                    sio_d     = register_addr[0];
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_inc;
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    slot_d  = '0;
                    phase_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_inc;
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        // End of the low half: rise SCLK, capture read bits.
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                        if (mode_rd_q && slot_q[3]) begin
                            shift_d[slot_q[2:0]] = ds_sio;
                        end
                    end else begin
                        // End of the high half: fall SCLK, present next bit.
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (slot_q == 4'd15) begin
                            state_d = ST_HOLD;
                            oe_d    = 1'b0;
                        end else begin
                            slot_d = next_slot;
                            if (mode_rd_q && next_slot[3]) begin
                                oe_d = 1'b0;
                            end else begin
                                sio_d = next_slot[3] ? data_q[next_slot[2:0]]
                                                     : addr_q[next_slot[2:0]];
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_inc;
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                    rst_d   = 1'b0;
                end
            end
            ST_RECOVER: begin
                cnt_d = cnt_inc;
                if (cnt_q == REC_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (mode_rd_q) begin
                        rdata_d = shift_q;
                    end
                end
            end
            // A request still held after done must not start a second transaction.
            ST_DONE:  state_d = (func_start == 2'b00) ? ST_IDLE : ST_REARM;
            ST_REARM: begin
                if (func_start == 2'b00) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            phase_q   <= 1'b0;
            mode_rd_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            rst_q     <= 1'b0;
            sclk_q    <= 1'b0;
            done_q    <= 1'b0;
            oe_q      <= 1'b0;
            sio_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            phase_q   <= phase_d;
            mode_rd_q <= mode_rd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            rst_q     <= rst_d;
            sclk_q    <= sclk_d;
            done_q    <= done_d;
            oe_q      <= oe_d;
            sio_q     <= sio_d;
        end
    end

    assign func_done = done_q;
    assign read_data = rdata_q;
    assign ds_rst    = rst_q;
    assign ds_sclk   = sclk_q;
    assign ds_sio    = oe_q ? sio_q : 1'bz;

endmodule

// File: tb/tb_ds_serial_engine.sv
// tb_ds_serial_engine
// Self-checking bench for ds_serial_engine with short timing parameters.
// A transaction-level model predicts CE/SCLK/SIO/done/read_data for every
// cycle from the time elapsed since acceptance. A behavioural DS1302 device
// samples SIO on SCLK rises and answers reads. Directed scenarios are
// followed by randomized transactions.
module tb_ds_serial_engine;

    localparam int HP        = 2;
    localparam int CS        = 4;
    localparam int CH        = 2;
    localparam int CR        = 4;
    localparam int SHIFT_END = CS + 32 * HP;       // final SCLK fall
    localparam int RST_END   = SHIFT_END + CH;     // CE drops
    localparam int DONE_K    = RST_END + CR;       // done pulse
    localparam int RD_REL    = CS + 16 * HP;       // SIO released on reads

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] func_start = 2'b00;
    logic [7:0] register_addr = 8'h00;
    logic [7:0] write_data = 8'h00;
    logic       func_done;
    logic [7:0] read_data;
    logic       ds_rst;
    logic       ds_sclk;
    wire        ds_sio;

    logic       dev_oe = 1'b0;
    logic       dev_val = 1'b0;
    logic [7:0] dev_byte = 8'h00;
    assign ds_sio = dev_oe ? dev_val : 1'bz;

    ds_serial_engine #(
        .HALF_PERIOD(HP),
        .CE_SETUP   (CS),
        .CE_HOLD    (CH),
        .CE_RECOVER (CR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .func_start   (func_start),
        .register_addr(register_addr),
        .write_data   (write_data),
        .func_done    (func_done),
        .read_data    (read_data),
        .ds_rst       (ds_rst),
        .ds_sclk      (ds_sclk),
        .ds_sio       (ds_sio)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model
    int          cyc = 0;
    int          m_e0 = 0;
    int          m_done_cyc = -1;
    bit          m_busy = 1'b0;
    bit          m_wait = 1'b0;
    bit          m_rd = 1'b0;
    logic [15:0] m_frame = 16'h0;
    logic [7:0]  m_rd_exp = 8'h00;
    logic [15:0] exp_frames[$];
    logic [15:0] frames[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     = 1'b0;
            m_wait     = 1'b0;
            m_done_cyc = -1;
            m_rd_exp   = 8'h00;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc - m_e0 == DONE_K) begin
                    m_busy     = 1'b0;
                    m_wait     = 1'b1;
                    m_done_cyc = cyc;
                    if (m_rd) m_rd_exp = m_frame[15:8];
                    exp_frames.push_back(m_frame);
                end
            end else if (m_wait) begin
                if (cyc > m_done_cyc && func_start == 2'b00) m_wait = 1'b0;
            end else if (func_start == 2'b10 || func_start == 2'b01) begin
                m_busy  = 1'b1;
                m_e0    = cyc;
                m_rd    = func_start[0];
                m_frame = {(func_start[0] ? dev_byte : write_data), register_addr};
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        int k;
        int idx;
        bit e_rst;
        bit e_sclk;
        bit e_done;
        k      = cyc - m_e0;
        e_rst  = m_busy && (k < RST_END);
        e_sclk = m_busy && (k >= CS) && (k < SHIFT_END) && ((((k - CS) / HP) % 2) == 1);
        e_done = rst_n && (m_done_cyc == cyc);
        check("ds_rst", {31'd0, ds_rst}, {31'd0, e_rst});
        check("ds_sclk", {31'd0, ds_sclk}, {31'd0, e_sclk});
        check("func_done", {31'd0, func_done}, {31'd0, e_done});
        check("read_data", {24'd0, read_data}, {24'd0, m_rd_exp});
        if (m_busy && k < (m_rd ? RD_REL : SHIFT_END)) begin
            idx = (k < CS) ? 0 : (k - CS) / (2 * HP);
            check("ds_sio", {31'd0, ds_sio}, {31'd0, m_frame[idx]});
        end
        if (func_done) done_seen++;
    end

    // Behavioural DS1302: samples SIO on rises, answers reads after the 8th fall
    logic [15:0] dev_frame;
    int          dev_cnt;
    always begin
        @(posedge ds_rst);
        dev_cnt   = 0;
        dev_frame = 16'h0;
        while (ds_rst === 1'b1 && dev_cnt < 16) begin
            @(posedge ds_sclk or negedge ds_rst);
            if (ds_rst !== 1'b1) break;
            dev_frame[dev_cnt] = ds_sio;
            dev_cnt++;
            @(negedge ds_sclk or negedge ds_rst);
            if (ds_rst !== 1'b1) break;
            if (dev_cnt >= 8 && dev_cnt < 16 && dev_frame[0]) begin
                #1;
                dev_val = dev_byte[dev_cnt - 8];
                dev_oe  = 1'b1;
            end else begin
                dev_oe = 1'b0;
            end
        end
        dev_oe = 1'b0;
        if (dev_cnt == 16) frames.push_back(dev_frame);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_rd = 8'h00;

    task automatic run_txn(input logic [1:0] fs, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] scr, input int hold);
        int lat;
        func_start    = fs;
        register_addr = a;
        write_data    = d;
        tick(1);
        // Inputs changing after acceptance must not affect the transfer
        register_addr = scr;
        write_data    = ~d;
        lat = 0;
        while (func_done !== 1'b1 && lat < 400) begin
            tick(1);
            lat++;
        end
        check("done_latency", lat, DONE_K);
        if (fs == 2'b01) exp_rd = dev_byte;
        check("read_data_at_done", {24'd0, read_data}, {24'd0, exp_rd});
        repeat (hold) tick(1);
        func_start = 2'b00;
    endtask

    function automatic logic [15:0] last_frame();
        return (frames.size() > 0) ? frames[frames.size() - 1] : 16'hDEAD;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int f0;
        int rises;
        int n;
        int cnt_rst;
        int cnt_sclk;
        bit prev;

        // Reset state
        tick(3);
        check("reset_ds_rst", {31'd0, ds_rst}, 32'd0);
        check("reset_sclk", {31'd0, ds_sclk}, 32'd0);
        check("reset_done", {31'd0, func_done}, 32'd0);
        check("reset_read_data", {24'd0, read_data}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: write 0x22 to 0x84
        run_txn(2'b10, 8'h84, 8'h22, 8'h5A, 0);
        check("t1_frame", {16'd0, last_frame()}, 32'h2284);
        tick(2);
        check("t1_read_data_unchanged", {24'd0, read_data}, 32'h00);

        // 2: read 0x85, device returns 0x13
        dev_byte = 8'h13;
        run_txn(2'b01, 8'h85, 8'h00, 8'hC3, 0);
        check("t2_read_data", {24'd0, read_data}, 32'h13);
        check("t2_frame", {16'd0, last_frame()}, 32'h1385);
        tick(2);

        // 3: request held one cycle after done, then a read; then minimum gap
        d0 = done_seen;
        f0 = frames.size();
        dev_byte = 8'hA6;
        run_txn(2'b10, 8'h8E, 8'h80, 8'h11, 1);
        tick(1);
        run_txn(2'b01, 8'h8F, 8'h00, 8'h22, 0);
        tick(1);
        dev_byte = 8'h3D;
        run_txn(2'b01, 8'h8D, 8'h00, 8'h33, 0);
        tick(3);
        check("t3_done_count", done_seen - d0, 32'd3);
        check("t3_frame_count", frames.size() - f0, 32'd3);
        check("t3_read_data", {24'd0, read_data}, 32'h3D);

        // 4: illegal request is ignored; address change mid-write has no effect
        d0 = done_seen;
        cnt_rst = 0;
        cnt_sclk = 0;
        func_start = 2'b11;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (ds_rst) cnt_rst++;
            if (ds_sclk) cnt_sclk++;
        end
        func_start = 2'b00;
        check("t4_illegal_ce", cnt_rst, 32'd0);
        check("t4_illegal_sclk", cnt_sclk, 32'd0);
        check("t4_illegal_done", done_seen - d0, 32'd0);
        tick(1);
        run_txn(2'b10, 8'h80, 8'h45, 8'hFF, 0);
        check("t4_frame", {16'd0, last_frame()}, 32'h4580);
        tick(2);

        // 5: reset at SCLK pulse 5 of a read
        d0 = done_seen;
        f0 = frames.size();
        dev_byte = 8'hE7;
        func_start = 2'b01;
        register_addr = 8'h81;
        tick(1);
        func_start = 2'b00;
        rises = 0;
        n = 0;
        prev = 1'b0;
        while (rises < 5 && n < 300) begin
            tick(1);
            n++;
            if (ds_sclk && !prev) rises++;
            prev = ds_sclk;
        end
        check("t5_pulse5_reached", rises, 32'd5);
        rst_n = 1'b0;
        #1;
        check("t5_async_ce", {31'd0, ds_rst}, 32'd0);
        check("t5_async_sclk", {31'd0, ds_sclk}, 32'd0);
        check("t5_async_read_data", {24'd0, read_data}, 32'd0);
        exp_rd = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t5_no_done", done_seen - d0, 32'd0);
        check("t5_no_frame", frames.size() - f0, 32'd0);
        dev_byte = 8'h3C;
        run_txn(2'b01, 8'h83, 8'h00, 8'h00, 0);
        check("t5_recovery_read", {24'd0, read_data}, 32'h3C);
        tick(2);

        // 6: back-to-back reads
        dev_byte = 8'h59;
        run_txn(2'b01, 8'h81, 8'h00, 8'h7E, 0);
        check("t6_first", {24'd0, read_data}, 32'h59);
        tick(1);
        dev_byte = 8'h07;
        run_txn(2'b01, 8'h83, 8'h00, 8'h81, 0);
        check("t6_second", {24'd0, read_data}, 32'h07);
        tick(2);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            logic [1:0] fs;
            logic [7:0] a;
            fs = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            a  = 8'($urandom);
            a[0] = fs[0];
            dev_byte = 8'($urandom);
            run_txn(fs, a, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
            tick(1);
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                func_start = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                tick(1);
            end
            func_start = 2'b00;
        end
        tick(4);

        // Every completed transfer seen on the wire matches the model
        check("frame_count", frames.size(), exp_frames.size());
        for (int i = 0; i < frames.size() && i < exp_frames.size(); i++) begin
            check("frame", {16'd0, frames[i]}, {16'd0, exp_frames[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ds_serial_engine.md
Name: ds_serial_engine

Overview:
Bit-level 3-wire serial engine for the DS1302 RTC, directly downstream of the command sequencer. It accepts a single-transaction request (write or read) as an 8-bit register address plus 8-bit write data. It generates the CE, SCLK and bidirectional SIO waveforms, then returns a one-cycle func_done pulse and, for reads, the captured byte. The request/done handshake is the same func_start/func_done pair the command sequencer drives.

Parameters:
HALF_PERIOD, 50, clk cycles per SCLK half-period (50 MHz clk -> 500 kHz SCLK); legal range >= 2.
CE_SETUP, 200, clk cycles CE high before first SCLK rise window (slot 0 low half begins after this).
CE_HOLD, 50, clk cycles CE held high after final SCLK fall.
CE_RECOVER, 200, clk cycles CE low before func_done is pulsed.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
func_start  input  2  2'b10 write request, 2'b01 read request, 2'b00 idle, 2'b11 illegal
register_addr  input  8  DS1302 command byte, sent LSB first (bit0 = RD/W)
write_data  input  8  data byte for writes, sent LSB first
func_done  output  1  one-cycle pulse at transaction end
read_data  output  8  byte captured by last read, LSB received first
ds_rst  output  1  DS1302 CE pin, active high
ds_sclk  output  1  DS1302 SCLK
ds_sio  inout  1  DS1302 I/O; driven only while sio_oe internal = 1, else 1'bz

Behaviour:
- Reset (async, any state): ds_rst=0, ds_sclk=0, ds_sio released (z), func_done=0, read_data=8'h00, FSM=IDLE, all counters 0. Reset mid-transaction aborts immediately with no done pulse.
- All outputs registered. Internal regs: mode (write/read), addr_q, data_q, shift_in, div counter (clog2 of max param), slot counter 0..15, phase (low/high).
- States: IDLE -> SETUP -> SHIFT -> HOLD -> RECOVER -> DONE -> REARM -> IDLE.
- IDLE: on a clk edge with func_start==2'b10 or 2'b01 (acceptance edge E0), latch addr_q/data_q/mode, ds_rst<=1, go SETUP. 2'b11 and 2'b00 are ignored (stay IDLE). Input changes after E0 have no effect.
- SETUP: CE_SETUP cycles, ds_sclk=0, ds_sio driven with addr_q[0].
- SHIFT: 16 slots. Each slot = HALF_PERIOD cycles with sclk low, then HALF_PERIOD cycles with sclk high.
  - Slots 0-7: drive addr_q[slot] from the start of the low half; value is stable across the rising edge.
  - Write, slots 8-15: drive data_q[slot-8] likewise.
  - Read: release SIO on the same edge that ends slot 7's high half (SCLK fall). For k=0..7, sample ds_sio into shift_in[k] on the last clk of slot 8+k's low half. Slot 15 high half is still generated (16 pulses total in both modes).
- Timing from E0: SCLK rise n (n=0..15) at E0+CE_SETUP+(2n+1)*HALF_PERIOD. Final fall at E0+CE_SETUP+32*HALF_PERIOD.
- HOLD: sclk=0, SIO released, ds_rst=1 for CE_HOLD cycles, then ds_rst<=0.
- RECOVER: CE_RECOVER cycles, ds_rst=0.
- DONE: func_done=1 for exactly one cycle at E0+CE_SETUP+32*HALF_PERIOD+CE_HOLD+CE_RECOVER. On a read, read_data<=shift_in on the same edge. Writes leave read_data unchanged.
- REARM: wait until func_start==2'b00 is sampled, then IDLE. This guarantees a request still held one cycle after done is never re-accepted. Minimum gap between done and the next acceptance is 2 cycles.
- SIO is never driven while ds_rst=0 or during read data slots.

Test Plan:
Use HALF_PERIOD=2, CE_SETUP=4, CE_HOLD=2, CE_RECOVER=4 for all scenarios.
1. Write: func_start=2'b10, addr=8'h84, data=8'h22 -> ds_rst high cycles 1..70 after E0, 16 SCLK pulses; SIO sampled at rises = 0,0,1,0,0,0,0,1 then 0,1,0,0,0,1,0,0; func_done single pulse at E0+74; read_data unchanged.
2. Read: func_start=2'b01, addr=8'h85, model drives 8'h13 LSB first after each fall from the 8th onward -> SIO z from the 8th fall; func_done at E0+74 with read_data=8'h13 in that cycle.
3. Handshake: hold func_start=2'b10 for 1 cycle after done, then 00, then 2'b01 -> exactly one write then one read; no double acceptance; second E0 >= 2 cycles after first done.
4. Illegal/idle: func_start=2'b11 for 100 cycles -> ds_rst=0, sclk=0, no done; change register_addr mid-write to 8'hFF -> transmitted bytes unchanged.
5. Reset mid-transaction: assert rst_n=0 at SCLK pulse 5 -> ds_rst=0, ds_sclk=0, SIO z asynchronously, read_data=8'h00, no done; the next request completes normally.
6. Back-to-back reads 8'h81/8'h83 with model returning 8'h59/8'h07 -> read_data 8'h59 then 8'h07, each latched exactly on its done pulse.
